sim_run_ctrl: RTL and testbench

Synthesizable run controller for the multi-core CV32E40P simulation subsystem. It sequences core reset release and fetch enable, and collects per-core pass/fail/exit reports from the stdout/exit peripherals. It runs a cycle watchdog and presents one registered verdict that the bench top polls to end simulation. It generalises the single-core pass/fail/exit checking and reset sequencing to `NUM_CORES` channels with a runtime cycle limit.

---
 rtl/sim_run_ctrl_pkg.sv | 26 ++
 rtl/sim_reset_seq.sv | 37 +++
 rtl/sim_run_ctrl.sv | 177 +++++++++++++++++
 tb/tb_sim_run_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sim_run_ctrl_pkg.sv
// Shared types and constants for the simulation run controller.
// Feature macro used by the top: SIM_RUN_CTRL_TIMEOUT_EN (cycle watchdog).
package sim_run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        STATUS_RUNNING = 2'd0,
        STATUS_PASS    = 2'd1,
        STATUS_FAIL    = 2'd2,
        STATUS_TIMEOUT = 2'd3
    } status_e;

    // Exit code reported when a core signals failure through tests_failed_i.
    localparam logic [31:0] FAIL_CODE_TESTS_FAILED = 32'h0000_0001;

    // Index width for a core number, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sim_reset_seq.sv
// Holds the cores in reset for RESET_WAIT_CYCLES clocks after rst_n release,
// then releases them with a registered reset and a one-cycle release strobe.
module sim_reset_seq #(
    parameter int RESET_WAIT_CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_core_rst_n,
    output logic o_release
);

    localparam int            CW   = (RESET_WAIT_CYCLES > 1) ? $clog2(RESET_WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(RESET_WAIT_CYCLES - 1);

    logic [CW-1:0] r_cnt;
    logic          r_core_rst_n;
    logic          w_last;

    assign w_last       = (r_cnt == LAST);
    assign o_release    = ~r_core_rst_n & w_last;
    assign o_core_rst_n = r_core_rst_n;

    // Hold counter; the count parks at LAST once the cores are released.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt        <= '0;
            r_core_rst_n <= 1'b0;
        end else if (o_release) begin
            r_core_rst_n <= 1'b1;
        end else if (!r_core_rst_n) begin
            r_cnt <= r_cnt + CW'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

endmodule

// File: rtl/sim_run_ctrl.sv
// Multi-core run controller: reset/fetch sequencing, per-core verdict capture,
// cycle watchdog (built only with SIM_RUN_CTRL_TIMEOUT_EN) and a sticky verdict.
module sim_run_ctrl
    import sim_run_ctrl_pkg::*;
#(
    parameter int NUM_CORES         = 2,
    parameter int RESET_WAIT_CYCLES = 4,
    parameter int CNT_WIDTH         = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [CNT_WIDTH-1:0]            max_cycles_i,
    input  logic [NUM_CORES-1:0]            tests_passed_i,
    input  logic [NUM_CORES-1:0]            tests_failed_i,
    input  logic [NUM_CORES-1:0]            exit_valid_i,
    input  logic [NUM_CORES*32-1:0]         exit_value_i,
    output logic                            core_rst_no,
    output logic                            fetch_enable_o,
    output logic                            done_o,
    output logic [1:0]                      status_o,
    output logic [NUM_CORES-1:0]            finished_o,
    output logic [idx_width(NUM_CORES)-1:0] fail_core_o,
    output logic [31:0]                     fail_code_o,
    output logic [CNT_WIDTH-1:0]            cycle_cnt_o
);

    localparam int FCW = idx_width(NUM_CORES);

    state_e                      r_state;
    state_e                      w_next;
    status_e                     r_status;
    status_e                     w_status_nxt;
    logic                        r_fetch_en;
    logic                        r_done;
    logic [NUM_CORES-1:0]        r_finished;
    logic [FCW-1:0]              r_fail_core;
    logic [31:0]                 r_fail_code;
    logic [CNT_WIDTH-1:0]        r_cycle_cnt;

    logic                        w_release;
    logic                        w_run;
    logic [NUM_CORES-1:0]        w_ev_fail;
    logic [NUM_CORES-1:0]        w_ev_pass;
    logic [NUM_CORES-1:0][31:0]  w_ev_code;
    logic                        w_any_fail;
    logic                        w_all_fin;
    logic                        w_timeout;
    logic [FCW-1:0]              w_sel_core;
    logic [31:0]                 w_sel_code;

    sim_reset_seq #(
        .RESET_WAIT_CYCLES (RESET_WAIT_CYCLES)
    ) u_reset_seq (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .o_core_rst_n (core_rst_no),
        .o_release    (w_release)
    );

    assign w_run = (r_state == ST_RUN);

    // Only the first event of an unfinished core counts; fail outranks exit outranks pass.
    for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
        logic [31:0] w_code;
        logic        w_active;
        assign w_code       = exit_value_i[g*32 +: 32];
        assign w_active     = w_run & ~r_finished[g];
        assign w_ev_fail[g] = w_active & (tests_failed_i[g] | (exit_valid_i[g] & (w_code != 32'h0)));
        assign w_ev_pass[g] = w_active & ~w_ev_fail[g] & (exit_valid_i[g] | tests_passed_i[g]);
        assign w_ev_code[g] = tests_failed_i[g] ? FAIL_CODE_TESTS_FAILED : w_code;
    end

    assign w_any_fail = |w_ev_fail;
    assign w_all_fin  = &(r_finished | w_ev_pass | w_ev_fail);

`ifdef SIM_RUN_CTRL_TIMEOUT_EN
    assign w_timeout = (max_cycles_i != '0) && (r_cycle_cnt >= max_cycles_i);
`else
    logic w_unused_max_cycles;
    assign w_unused_max_cycles = ^max_cycles_i;
    assign w_timeout           = 1'b0;
`endif

    // Lowest-index failing core wins: scan downwards so index 0 is applied last.
    always_comb begin
        w_sel_core = '0;
        w_sel_code = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            w_sel_core = w_ev_fail[i] ? FCW'(i) : w_sel_core;
            w_sel_code = w_ev_fail[i] ? w_ev_code[i] : w_sel_code;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_HOLD;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and verdict; FAIL beats completion beats timeout.
    always_comb begin
        w_next       = r_state;
        w_status_nxt = r_status;
        case (r_state)
            ST_HOLD: begin
                if (w_release) begin
                    w_next = ST_RUN;
                end else begin
                    w_next = ST_HOLD;
                end
            end
            ST_RUN: begin
                if (w_any_fail) begin
                    w_next       = ST_DONE;
                    w_status_nxt = STATUS_FAIL;
                end else if (w_all_fin) begin
                    w_next       = ST_DONE;
                    w_status_nxt = STATUS_PASS;
                end else if (w_timeout) begin
                    w_next       = ST_DONE;
                    w_status_nxt = STATUS_TIMEOUT;
                end else begin
                    w_next = ST_RUN;
                end
            end
            ST_DONE: begin
                w_next = ST_DONE;
            end
            default: begin
                w_next       = ST_HOLD;
                w_status_nxt = STATUS_RUNNING;
            end
        endcase
    end

    // Output and bookkeeping registers; the counter stops on the edge entering DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_en  <= 1'b0;
            r_done      <= 1'b0;
            r_status    <= STATUS_RUNNING;
            r_finished  <= '0;
            r_fail_core <= '0;
            r_fail_code <= '0;
            r_cycle_cnt <= '0;
        end else begin
            r_fetch_en <= (w_next == ST_RUN);
            r_done     <= (w_next == ST_DONE);
            r_status   <= w_status_nxt;
            r_finished <= r_finished | w_ev_pass | w_ev_fail;
            if (w_run && (w_next == ST_RUN) && (r_cycle_cnt != '1)) begin
                r_cycle_cnt <= r_cycle_cnt + CNT_WIDTH'(1);
            end else begin
                r_cycle_cnt <= r_cycle_cnt;
            end
            if (w_any_fail) begin
                r_fail_core <= w_sel_core;
                r_fail_code <= w_sel_code;
            end else begin
                r_fail_core <= r_fail_core;
                r_fail_code <= r_fail_code;
            end
        end
    end

    assign fetch_enable_o = r_fetch_en;
    assign done_o         = r_done;
    assign status_o       = r_status;
    assign finished_o     = r_finished;
    assign fail_core_o    = r_fail_core;
    assign fail_code_o    = r_fail_code;
    assign cycle_cnt_o    = r_cycle_cnt;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Directed bench for sim_run_ctrl: expected values are queued when stimulus is
// driven and popped against the DUT outputs after the following clock edge.
module tb_sim_run_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] max_cycles_i;
    logic [1:0]  tests_passed_i;
    logic [1:0]  tests_failed_i;
    logic [1:0]  exit_valid_i;
    logic [63:0] exit_value_i;
    logic        core_rst_no;
    logic        fetch_enable_o;
    logic        done_o;
    logic [1:0]  status_o;
    logic [1:0]  finished_o;
    logic [0:0]  fail_core_o;
    logic [31:0] fail_code_o;
    logic [31:0] cycle_cnt_o;

    int n_checks = 0;
    int n_pass   = 0;

    string       tag_q[$];
    logic [63:0] val_q[$];

    sim_run_ctrl #(
        .NUM_CORES         (2),
        .RESET_WAIT_CYCLES (4),
        .CNT_WIDTH         (32)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .max_cycles_i   (max_cycles_i),
        .tests_passed_i (tests_passed_i),
        .tests_failed_i (tests_failed_i),
        .exit_valid_i   (exit_valid_i),
        .exit_value_i   (exit_value_i),
        .core_rst_no    (core_rst_no),
        .fetch_enable_o (fetch_enable_o),
        .done_o         (done_o),
        .status_o       (status_o),
        .finished_o     (finished_o),
        .fail_core_o    (fail_core_o),
        .fail_code_o    (fail_code_o),
        .cycle_cnt_o    (cycle_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_val(input string tag, input logic [63:0] v);
        tag_q.push_back(tag);
        val_q.push_back(v);
    endtask

    task automatic chk(input logic [63:0] obs);
        string       t;
        logic [63:0] e;
        n_checks++;
        if (val_q.size() == 0) begin
            $error("FAIL sb_empty: observed %0h with no expected value queued", obs);
        end else begin
            t = tag_q.pop_front();
            e = val_q.pop_front();
            assert (obs === e) n_pass++;
            else $error("FAIL %s: observed %0h expected %0h", t, obs, e);
        end
    endtask

    task automatic clear_inputs();
        tests_passed_i = 2'b00;
        tests_failed_i = 2'b00;
        exit_valid_i   = 2'b00;
        exit_value_i   = 64'h0;
    endtask

    task automatic check_reset_vals(input string t);
        exp_val({t, "_core_rst_no"}, 64'd0);
        exp_val({t, "_fetch"},       64'd0);
        exp_val({t, "_done"},        64'd0);
        exp_val({t, "_status"},      64'd0);
        exp_val({t, "_finished"},    64'd0);
        exp_val({t, "_fail_core"},   64'd0);
        exp_val({t, "_fail_code"},   64'd0);
        exp_val({t, "_cycle_cnt"},   64'd0);
        chk(64'(core_rst_no));
        chk(64'(fetch_enable_o));
        chk(64'(done_o));
        chk(64'(status_o));
        chk(64'(finished_o));
        chk(64'(fail_core_o));
        chk(64'(fail_code_o));
        chk(64'(cycle_cnt_o));
    endtask

    // Release rst_n and check core reset rises on exactly the 4th edge.
    task automatic release_reset(input string t);
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        exp_val({t, "_rst_edge3"}, 64'd0);
        chk(64'(core_rst_no));
        tick();
        exp_val({t, "_rst_edge4"},   64'd1);
        exp_val({t, "_fetch_edge4"}, 64'd1);
        exp_val({t, "_cnt_run0"},    64'd0);
        chk(64'(core_rst_no));
        chk(64'(fetch_enable_o));
        chk(64'(cycle_cnt_o));
    endtask

    task automatic restart(input string t, input logic [31:0] limit);
        clear_inputs();
        max_cycles_i = limit;
        rst_n = 1'b0;
        tick();
        release_reset(t);
    endtask

    // Advance until cycle_cnt_o reaches k (bounded) and check it got there.
    task automatic run_to(input string t, input int k);
        int guard = 0;
        while (int'(cycle_cnt_o) < k && done_o == 1'b0 && guard < 1000) begin
            tick();
            guard++;
        end
        exp_val({t, "_run_to"}, 64'(k));
        chk(64'(cycle_cnt_o));
    endtask

    initial begin
        rst_n = 1'b0;
        max_cycles_i = 32'd0;
        clear_inputs();
        tick();
        tick();
        check_reset_vals("init");
        release_reset("init");

        // Core0 exits 0 at cycle 10, core1 passes at cycle 20.
        run_to("t1a", 10);
        exit_valid_i = 2'b01;
        exp_val("t1_fin_core0", 64'd1);
        exp_val("t1_done_early", 64'd0);
        tick();
        clear_inputs();
        chk(64'(finished_o));
        chk(64'(done_o));
        run_to("t1b", 20);
        tests_passed_i = 2'b10;
        exp_val("t1_done",   64'd1);
        exp_val("t1_status", 64'd1);
        exp_val("t1_fin",    64'd3);
        exp_val("t1_cnt",    64'd20);
        exp_val("t1_fetch",  64'd0);
        tick();
        clear_inputs();
        chk(64'(done_o));
        chk(64'(status_o));
        chk(64'(finished_o));
        chk(64'(cycle_cnt_o));
        chk(64'(fetch_enable_o));
        exp_val("t1_freeze_cnt", 64'd20);
        exp_val("t1_core_rst",   64'd1);
        tick();
        tick();
        chk(64'(cycle_cnt_o));
        chk(64'(core_rst_no));

        // Core1 exits with code 5 at cycle 7.
        restart("t2", 32'd0);
        run_to("t2", 7);
        exit_valid_i = 2'b10;
        exit_value_i = 64'h0000_0005_0000_0000;
        exp_val("t2_done",      64'd1);
        exp_val("t2_status",    64'd2);
        exp_val("t2_fail_core", 64'd1);
        exp_val("t2_fail_code", 64'd5);
        exp_val("t2_fetch",     64'd0);
        exp_val("t2_fin",       64'd2);
        tick();
        clear_inputs();
        chk(64'(done_o));
        chk(64'(status_o));
        chk(64'(fail_core_o));
        chk(64'(fail_code_o));
        chk(64'(fetch_enable_o));
        chk(64'(finished_o));

        // Watchdog limit 100 with no events.
        restart("t3", 32'd100);
        run_to("t3", 100);
        exp_val("t3_done_at100", 64'd0);
        chk(64'(done_o));
`ifdef SIM_RUN_CTRL_TIMEOUT_EN
        exp_val("t3_done",   64'd1);
        exp_val("t3_status", 64'd3);
        exp_val("t3_cnt",    64'd100);
        exp_val("t3_fetch",  64'd0);
`else
        exp_val("t3_done",   64'd0);
        exp_val("t3_status", 64'd0);
        exp_val("t3_cnt",    64'd101);
        exp_val("t3_fetch",  64'd1);
`endif
        tick();
        chk(64'(done_o));
        chk(64'(status_o));
        chk(64'(cycle_cnt_o));
        chk(64'(fetch_enable_o));

        // Same cycle: core0 fail, core1 pass, limit reached.
        restart("t4", 32'd5);
        run_to("t4", 5);
        tests_failed_i = 2'b01;
        tests_passed_i = 2'b10;
        exp_val("t4_status",    64'd2);
        exp_val("t4_fail_core", 64'd0);
        exp_val("t4_fail_code", 64'd1);
        exp_val("t4_fin",       64'd3);
        tick();
        clear_inputs();
        chk(64'(status_o));
        chk(64'(fail_core_o));
        chk(64'(fail_code_o));
        chk(64'(finished_o));

        // Same cycle: completion and limit reached -> completion wins.
        restart("t4b", 32'd3);
        run_to("t4b", 3);
        tests_passed_i = 2'b11;
        exp_val("t4b_status", 64'd1);
        exp_val("t4b_done",   64'd1);
        tick();
        clear_inputs();
        chk(64'(status_o));
        chk(64'(done_o));

        // Duplicate events: core0 pass, then core0 fail 3 cycles later.
        restart("t5", 32'd0);
        run_to("t5a", 2);
        tests_passed_i = 2'b01;
        exp_val("t5_fin_pass", 64'd1);
        tick();
        clear_inputs();
        chk(64'(finished_o));
        run_to("t5b", 5);
        tests_failed_i = 2'b01;
        exp_val("t5_dup_done",   64'd0);
        exp_val("t5_dup_status", 64'd0);
        exp_val("t5_dup_fin",    64'd1);
        tick();
        clear_inputs();
        chk(64'(done_o));
        chk(64'(status_o));
        chk(64'(finished_o));
        exit_valid_i = 2'b10;
        exp_val("t5_final_status", 64'd1);
        exp_val("t5_fail_code",    64'd0);
        tick();
        clear_inputs();
        chk(64'(status_o));
        chk(64'(fail_code_o));

        // rst_n pulsed low mid-RUN at cycle 50.
        restart("t6", 32'd0);
        run_to("t6a", 10);
        tests_passed_i = 2'b01;
        tick();
        clear_inputs();
        run_to("t6b", 50);
        rst_n = 1'b0;
        #2;
        check_reset_vals("t6_async");
        tick();
        tick();
        release_reset("t6");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
